// File: rtl/div_pkg.sv
// Shared types and constants for the radix-2 non-restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int DIV_WIDTH = 8;
  localparam int CNT_W     = $clog2(DIV_WIDTH);
  localparam logic [DIV_WIDTH-1:0] DZ_QUOTIENT = '1;

  // Iteration counter width for an arbitrary operand width (WIDTH >= 2).
  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/div_addsub.sv
// Shared add/sub for the divider: sub inverts b and doubles as the carry-in.
module div_addsub #(
  parameter int N = 9
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  output logic [N-1:0] sum
);

  assign sum = a + (b ^ {N{sub}}) + N'(sub);

endmodule

// File: rtl/nonrestoring_divider.sv
// Sequential radix-2 non-restoring divider with valid/ready handshakes.
// Define SIGNED_DIV_EN for two's-complement operands (sign/magnitude wrapper around the core).
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// CALC  | one quotient bit per cycle, WIDTH cycles
// FIX   | final remainder correction and result load
// DONE  | result presented until out_ready
module nonrestoring_divider
  import div_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   p;
  logic [WIDTH-1:0] q_sr;
  logic [WIDTH-1:0] d_reg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   add_a;
  logic [WIDTH:0]   add_b;
  logic             add_sub;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   p_fix;
  logic             accept;

`ifdef SIGNED_DIV_EN
  logic neg_q;
  logic neg_r;
  assign a_mag = dividend[WIDTH-1] ? (~dividend + 1'b1) : dividend;
  assign b_mag = divisor[WIDTH-1]  ? (~divisor + 1'b1)  : divisor;
`else
  assign a_mag = dividend;
  assign b_mag = divisor;
`endif

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;

  // CALC shifts the next dividend bit into P; FIX adds D back when P ended negative.
  always_comb begin
    add_a   = p;
    add_sub = 1'b0;
    if (state == CALC) begin
      add_a   = {p[WIDTH-1:0], q_sr[WIDTH-1]};
      add_sub = ~p[WIDTH];
    end
  end

  assign add_b = {1'b0, d_reg};
  assign p_fix = p[WIDTH] ? add_sum : p;

  div_addsub #(.N(WIDTH + 1)) u_addsub (
    .a   (add_a),
    .b   (add_b),
    .sub (add_sub),
    .sum (add_sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      p           <= '0;
      q_sr        <= '0;
      d_reg       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
`ifdef SIGNED_DIV_EN
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            p     <= '0;
            q_sr  <= a_mag;
            d_reg <= b_mag;
`ifdef SIGNED_DIV_EN
            neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            neg_r <= dividend[WIDTH-1];
`endif
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              state       <= DONE;
            end else begin
              div_by_zero <= 1'b0;
              cnt         <= CW'(WIDTH - 1);
              state       <= CALC;
            end
          end
        end
        CALC: begin
          p    <= add_sum;
          q_sr <= {q_sr[WIDTH-2:0], ~add_sum[WIDTH]};
          cnt  <= cnt - 1'b1;
          if (cnt == '0) state <= FIX;
        end
        FIX: begin
          p <= p_fix;
`ifdef SIGNED_DIV_EN
          quotient  <= neg_q ? (~q_sr + 1'b1) : q_sr;
          remainder <= neg_r ? (~p_fix[WIDTH-1:0] + 1'b1) : p_fix[WIDTH-1:0];
`else
          quotient  <= q_sr;
          remainder <= p_fix[WIDTH-1:0];
`endif
          state <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
